// File: rtl/prog_counter_pkg.sv
// prog_counter shared definitions: mode encodings and direction levels.
// Used by prog_counter and prog_counter_presc.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_UP_SAT    = 2'b10,
    MODE_BOUNCE    = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/prog_counter_presc.sv
// Clock-enable prescaler: strobes once every presc+1 enabled cycles.
// Built only when PROG_COUNTER_PRESCALER_EN is defined.
module prog_counter_presc
  import prog_counter_pkg::*;
#(
  parameter int PRESC_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               o_strobe
);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_hit;

  assign w_hit    = (r_cnt == i_presc);
  assign o_strobe = w_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_hit ? '0 : r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable counter: wrap/saturate/bounce modes, limit, load, tc pulse.
// Optional prescaler enabled by defining PROG_COUNTER_PRESCALER_EN.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               dir
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_dir;

  logic             w_strobe;
  logic             w_tick;
  logic [WIDTH-1:0] w_nc;
  logic             w_ntc;
  logic             w_ndir;
  logic [WIDTH-1:0] w_load_c;
  logic             w_at_lim;
  logic             w_zero;
  logic             w_lim0;
  mode_e            w_mode;

`ifdef PROG_COUNTER_PRESCALER_EN
  prog_counter_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (load),
    .i_en     (en),
    .i_presc  (presc),
    .o_strobe (w_strobe)
  );
`else
  logic w_unused;
  assign w_unused = ^presc;
  assign w_strobe = 1'b1;
`endif

  assign w_mode   = mode_e'(mode);
  assign w_tick   = en & w_strobe;
  assign w_at_lim = (r_count >= limit);
  assign w_zero   = (r_count == '0);
  assign w_lim0   = (limit == '0);
  assign w_load_c = (load_val > limit) ? limit : load_val;

  always_comb begin
    w_nc   = r_count;
    w_ntc  = 1'b0;
    w_ndir = (w_mode == MODE_DOWN_WRAP) ? DIR_DOWN : DIR_UP;
    if (w_mode == MODE_BOUNCE) w_ndir = r_dir;
    if (w_tick) begin
      unique case (w_mode)
        MODE_UP_WRAP: begin
          if (w_at_lim) begin
            w_nc  = '0;
            w_ntc = 1'b1;
          end else begin
            w_nc = r_count + ONE;
          end
        end
        MODE_DOWN_WRAP: begin
          if (w_zero) begin
            w_nc  = limit;
            w_ntc = 1'b1;
          end else if (r_count > limit) begin
            w_nc = limit;
          end else begin
            w_nc = r_count - ONE;
          end
        end
        MODE_UP_SAT: begin
          if (!w_at_lim) begin
            w_nc  = r_count + ONE;
            w_ntc = (r_count + ONE == limit);
          end else begin
            w_nc = limit;
          end
        end
        MODE_BOUNCE: begin
          // Turnaround steps one away from the end it just hit
          if (r_dir == DIR_UP) begin
            if (w_at_lim) begin
              w_ndir = DIR_DOWN;
              w_nc   = w_lim0 ? '0 : limit - ONE;
              w_ntc  = 1'b1;
            end else begin
              w_nc = r_count + ONE;
            end
          end else begin
            if (w_zero) begin
              w_ndir = DIR_UP;
              w_nc   = w_lim0 ? '0 : ONE;
              w_ntc  = 1'b1;
            end else begin
              w_nc = r_count - ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_dir   <= DIR_UP;
    end else if (load) begin
      r_count <= w_load_c;
      r_tc    <= 1'b0;
      r_dir   <= (w_mode == MODE_DOWN_WRAP) ? DIR_DOWN : DIR_UP;
    end else begin
      r_count <= w_nc;
      r_tc    <= w_ntc;
      r_dir   <= w_ndir;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign dir   = r_dir;

endmodule
